// File: rtl/ff_checker.sv
// Response checker: pipelines {en, d} by LATENCY edges and compares the
// aged stimulus against q. It keeps match/mismatch counts and captures the first mismatch.
module ff_checker #(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   input  logic [WIDTH-1:0] q,
   output logic             err_pulse,
   output logic             err_sticky,
   output logic [15:0]      match_cnt,
   output logic [7:0]       err_cnt,
   output logic [15:0]      first_err_cyc,
   output logic [WIDTH-1:0] first_err_exp,
   output logic [WIDTH-1:0] first_err_got,
   output logic [1:0]       state
);

   localparam int LAST = LATENCY - 1;
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FILL  = 2'd1;
   localparam logic [1:0] ST_CHECK = 2'd2;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   logic [LATENCY-1:0]            vld_r;
   logic [LATENCY-1:0][WIDTH-1:0] data_r;
   logic [LATENCY:0]              vld_ext_s;
   logic [LATENCY:0][WIDTH-1:0]   data_ext_s;
   logic [LATENCY-1:0]            vld_nxt_s;
   logic [1:0]                    state_r;
   logic [1:0]                    state_nxt_s;
   logic                          cmp_act_s;
   logic                          hit_s;
   logic                          miss_s;
   logic                          err_pulse_r;
   logic                          err_sticky_r;
   logic [15:0]                   match_cnt_r;
   logic [7:0]                    err_cnt_r;
   logic [15:0]                   cyc_cnt_r;
   logic [15:0]                   first_err_cyc_r;
   logic [WIDTH-1:0]              first_err_exp_r;
   logic [WIDTH-1:0]              first_err_got_r;

   assign vld_ext_s  = {vld_r, en};
   assign data_ext_s = {data_r, d};

   // Next stage valid bits; clr empties the pipeline in the same edge.
   always_comb begin
      vld_nxt_s = {LATENCY{1'b0}};
      if (clr) begin
         vld_nxt_s = {LATENCY{1'b0}};
      end else begin
         vld_nxt_s = vld_ext_s[LATENCY-1:0];
      end
   end

   // Checker state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state follows the post-update valid bits.
   always_comb begin
      state_nxt_s = ST_IDLE;
      if (vld_nxt_s[LAST]) begin
         state_nxt_s = ST_CHECK;
      end else if (|vld_nxt_s) begin
         state_nxt_s = ST_FILL;
      end else begin
         state_nxt_s = ST_IDLE;
      end
   end

   // CHECK means the last stage is valid, so a compare happens this edge
   // unless clr discards it; !== makes X/Z on q count as a mismatch.
   always_comb begin
      cmp_act_s = 1'b0;
      case (state_r)
         ST_CHECK: cmp_act_s = !clr;
         ST_IDLE:  cmp_act_s = 1'b0;
         ST_FILL:  cmp_act_s = 1'b0;
         default:  cmp_act_s = 1'b0;
      endcase
      hit_s  = cmp_act_s && (q === data_r[LAST]);
      miss_s = cmp_act_s && (q !== data_r[LAST]);
   end

   // Pipeline, counters, flags and first-mismatch capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vld_r           <= {LATENCY{1'b0}};
         data_r          <= {(LATENCY*WIDTH){1'b0}};
         err_pulse_r     <= 1'b0;
         err_sticky_r    <= 1'b0;
         match_cnt_r     <= 16'd0;
         err_cnt_r       <= 8'd0;
         cyc_cnt_r       <= 16'd0;
         first_err_cyc_r <= 16'd0;
         first_err_exp_r <= {WIDTH{1'b0}};
         first_err_got_r <= {WIDTH{1'b0}};
      end else if (clr) begin
         vld_r           <= {LATENCY{1'b0}};
         data_r          <= {(LATENCY*WIDTH){1'b0}};
         err_pulse_r     <= 1'b0;
         err_sticky_r    <= 1'b0;
         match_cnt_r     <= 16'd0;
         err_cnt_r       <= 8'd0;
         cyc_cnt_r       <= 16'd0;
         first_err_cyc_r <= 16'd0;
         first_err_exp_r <= {WIDTH{1'b0}};
         first_err_got_r <= {WIDTH{1'b0}};
      end else begin
         vld_r       <= vld_nxt_s;
         data_r      <= data_ext_s[LATENCY-1:0];
         cyc_cnt_r   <= cyc_cnt_r + 16'd1;
         err_pulse_r <= miss_s;
         if (hit_s) begin
            match_cnt_r <= sat_inc16(match_cnt_r);
         end
         if (miss_s) begin
            err_cnt_r    <= sat_inc8(err_cnt_r);
            err_sticky_r <= 1'b1;
            if (!err_sticky_r) begin
               first_err_cyc_r <= cyc_cnt_r;
               first_err_exp_r <= data_r[LAST];
               first_err_got_r <= q;
            end
         end
      end
   end

   assign err_pulse     = err_pulse_r;
   assign err_sticky    = err_sticky_r;
   assign match_cnt     = match_cnt_r;
   assign err_cnt       = err_cnt_r;
   assign first_err_cyc = first_err_cyc_r;
   assign first_err_exp = first_err_exp_r;
   assign first_err_got = first_err_got_r;
   assign state         = state_r;

endmodule

// File: tb/tb_ff_checker.sv
// Directed bench for ff_checker: one LATENCY=1 and one LATENCY=3 instance,
// driven at the falling edge and checked after it.
module tb_ff_checker;

   logic        clk;
   logic        reset_n;
   logic        en1, clr1, en3, clr3;
   logic [7:0]  d1, q1, d3, q3;
   logic        pulse1, sticky1, pulse3, sticky3;
   logic [15:0] mcnt1, fcyc1, mcnt3, fcyc3;
   logic [7:0]  ecnt1, fexp1, fgot1, ecnt3, fexp3, fgot3;
   logic [1:0]  st1, st3;
   int          n_chk;
   int          n_fail;

   ff_checker #(.WIDTH(8), .LATENCY(1)) u1 (
      .clk(clk), .reset_n(reset_n), .en(en1), .clr(clr1), .d(d1), .q(q1),
      .err_pulse(pulse1), .err_sticky(sticky1), .match_cnt(mcnt1), .err_cnt(ecnt1),
      .first_err_cyc(fcyc1), .first_err_exp(fexp1), .first_err_got(fgot1), .state(st1));

   ff_checker #(.WIDTH(8), .LATENCY(3)) u3 (
      .clk(clk), .reset_n(reset_n), .en(en3), .clr(clr3), .d(d3), .q(q3),
      .err_pulse(pulse3), .err_sticky(sticky3), .match_cnt(mcnt3), .err_cnt(ecnt3),
      .first_err_cyc(fcyc3), .first_err_exp(fexp3), .first_err_got(fgot3), .state(st3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_zero1(input string tag);
      chk({tag, "_pulse"}, {31'd0, pulse1}, 32'd0);
      chk({tag, "_sticky"}, {31'd0, sticky1}, 32'd0);
      chk({tag, "_mcnt"}, {16'd0, mcnt1}, 32'd0);
      chk({tag, "_ecnt"}, {24'd0, ecnt1}, 32'd0);
      chk({tag, "_fcyc"}, {16'd0, fcyc1}, 32'd0);
      chk({tag, "_fexp"}, {24'd0, fexp1}, 32'd0);
      chk({tag, "_fgot"}, {24'd0, fgot1}, 32'd0);
      chk({tag, "_state"}, {30'd0, st1}, 32'd0);
   endtask

   logic       t3_en [7];
   logic [7:0] t3_d  [7];
   logic [7:0] t3_q  [7];
   logic [1:0] t3_st [7];
   logic [7:0] t3_mc [7];

   initial begin
      n_chk = 0; n_fail = 0;
      reset_n = 1'b0;
      en1 = 1'b0; clr1 = 1'b0; d1 = 8'd0; q1 = 8'd0;
      en3 = 1'b0; clr3 = 1'b0; d3 = 8'd0; q3 = 8'd0;
      @(negedge clk);
      chk_zero1("rst");
      chk("rst_state3", {30'd0, st3}, 32'd0);
      reset_n = 1'b1;

      // Clean run, LATENCY 1, q = d delayed by one edge
      for (int k = 1; k <= 20; k++) begin
         en1 = 1'b1; d1 = 8'(k); q1 = (k == 1) ? 8'd0 : 8'(k - 1);
         tick();
         chk("clean_state", {30'd0, st1}, 32'd2);
         chk("clean_mcnt", {16'd0, mcnt1}, 32'(k - 1));
      end
      en1 = 1'b0; d1 = 8'd0; q1 = 8'd20;
      tick();
      chk("clean_mcnt_end", {16'd0, mcnt1}, 32'd20);
      chk("clean_ecnt", {24'd0, ecnt1}, 32'd0);
      chk("clean_sticky", {31'd0, sticky1}, 32'd0);
      chk("clean_idle", {30'd0, st1}, 32'd0);

      // Forced error at the 5th compare
      clr1 = 1'b1; tick(); clr1 = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         en1 = 1'b1; d1 = 8'(k);
         q1 = (k == 1) ? 8'd0 : ((k == 6) ? 8'hFA : 8'(k - 1));
         tick();
         if (k == 6) begin
            chk("ferr_pulse", {31'd0, pulse1}, 32'd1);
            chk("ferr_ecnt", {24'd0, ecnt1}, 32'd1);
            chk("ferr_mcnt", {16'd0, mcnt1}, 32'd4);
         end
         if (k == 7) begin
            chk("ferr_pulse_drop", {31'd0, pulse1}, 32'd0);
            chk("ferr_mcnt_next", {16'd0, mcnt1}, 32'd5);
         end
      end
      en1 = 1'b0; q1 = 8'd10;
      tick();
      chk("ferr_mcnt_end", {16'd0, mcnt1}, 32'd9);
      chk("ferr_ecnt_end", {24'd0, ecnt1}, 32'd1);
      chk("ferr_sticky", {31'd0, sticky1}, 32'd1);
      chk("ferr_fexp", {24'd0, fexp1}, 32'h05);
      chk("ferr_fgot", {24'd0, fgot1}, 32'hFA);
      chk("ferr_fcyc", {16'd0, fcyc1}, 32'd5);

      // X on q during a valid compare is a mismatch; capture stays frozen
      en1 = 1'b1; d1 = 8'h33; q1 = 8'h00;
      tick();
      en1 = 1'b0; q1 = 8'hxx;
      tick();
      chk("x_pulse", {31'd0, pulse1}, 32'd1);
      chk("x_ecnt", {24'd0, ecnt1}, 32'd2);
      chk("x_mcnt", {16'd0, mcnt1}, 32'd9);
      chk("x_fexp", {24'd0, fexp1}, 32'h05);
      chk("x_fgot", {24'd0, fgot1}, 32'hFA);
      q1 = 8'h00;

      // clr coincident with a mismatching compare
      en1 = 1'b1; d1 = 8'h44; q1 = 8'h00;
      tick();
      clr1 = 1'b1; en1 = 1'b1; d1 = 8'h55; q1 = 8'h00;
      tick();
      clr1 = 1'b0;
      chk("clr_pulse", {31'd0, pulse1}, 32'd0);
      chk("clr_ecnt", {24'd0, ecnt1}, 32'd0);
      chk("clr_state", {30'd0, st1}, 32'd0);
      chk("clr_sticky", {31'd0, sticky1}, 32'd0);
      en1 = 1'b1; d1 = 8'h66; q1 = 8'h00;
      tick();
      chk("clr_nocmp_ecnt", {24'd0, ecnt1}, 32'd0);
      chk("clr_nocmp_mcnt", {16'd0, mcnt1}, 32'd0);
      chk("clr_refill", {30'd0, st1}, 32'd2);
      en1 = 1'b0; q1 = 8'h66;
      tick();
      chk("clr_first_cmp", {16'd0, mcnt1}, 32'd1);

      // Mid-operation reset from CHECK with three errors
      en1 = 1'b1; d1 = 8'h10; q1 = 8'h00;
      tick();
      for (int k = 1; k <= 3; k++) begin
         d1 = 8'(8'h10 + k); q1 = 8'hEE;
         tick();
      end
      chk("mr_ecnt", {24'd0, ecnt1}, 32'd3);
      chk("mr_state", {30'd0, st1}, 32'd2);
      chk("mr_fexp", {24'd0, fexp1}, 32'h10);
      chk("mr_fgot", {24'd0, fgot1}, 32'hEE);
      chk("mr_fcyc", {16'd0, fcyc1}, 32'd3);
      d1 = 8'h14;
      #2 reset_n = 1'b0;
      #1 chk_zero1("mr_async");
      tick(); tick();
      chk_zero1("mr_held");
      reset_n = 1'b1;
      en1 = 1'b1; d1 = 8'h20; q1 = 8'hEE;
      tick();
      chk("mr_nocmp_ecnt", {24'd0, ecnt1}, 32'd0);
      chk("mr_nocmp_pulse", {31'd0, pulse1}, 32'd0);
      chk("mr_nocmp_state", {30'd0, st1}, 32'd2);
      en1 = 1'b0; q1 = 8'h20;
      tick();
      chk("mr_first_cmp", {16'd0, mcnt1}, 32'd1);
      chk("mr_first_ecnt", {24'd0, ecnt1}, 32'd0);

      // LATENCY 3 with en pattern 1,1,0,1
      t3_en = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      t3_d  = '{8'hA1, 8'hA2, 8'h00, 8'hA4, 8'h00, 8'h00, 8'h00};
      t3_q  = '{8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hFF, 8'hA4};
      t3_st = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd1, 2'd2, 2'd0};
      t3_mc = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd2, 8'd3};
      for (int e = 0; e < 7; e++) begin
         en3 = t3_en[e]; d3 = t3_d[e]; q3 = t3_q[e];
         tick();
         chk("lat3_state", {30'd0, st3}, {30'd0, t3_st[e]});
         chk("lat3_mcnt", {16'd0, mcnt3}, {24'd0, t3_mc[e]});
      end
      chk("lat3_ecnt", {24'd0, ecnt3}, 32'd0);
      chk("lat3_sticky", {31'd0, sticky3}, 32'd0);

      // 300 consecutive mismatches saturate err_cnt
      clr3 = 1'b1; tick(); clr3 = 1'b0;
      for (int e = 1; e <= 303; e++) begin
         en3 = (e <= 300);
         d3 = (e == 1) ? 8'h5A : 8'hC3;
         q3 = 8'h3C;
         tick();
         if (e == 4) begin
            chk("sat_first_pulse", {31'd0, pulse3}, 32'd1);
            chk("sat_first_ecnt", {24'd0, ecnt3}, 32'd1);
         end
         if (e == 258) chk("sat_reach", {24'd0, ecnt3}, 32'hFF);
      end
      chk("sat_ecnt", {24'd0, ecnt3}, 32'hFF);
      chk("sat_sticky", {31'd0, sticky3}, 32'd1);
      chk("sat_mcnt", {16'd0, mcnt3}, 32'd0);
      chk("sat_fexp", {24'd0, fexp3}, 32'h5A);
      chk("sat_fgot", {24'd0, fgot3}, 32'h3C);
      chk("sat_fcyc", {16'd0, fcyc3}, 32'd3);
      chk("sat_state", {30'd0, st3}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
